uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
Round-robin, packet-level arbiter that shares one UART TX FIFO write port among NumRequesters byte-stream sources. A granted source keeps the grant until its last byte is written. When HeaderEnable=1, the arbiter prefixes each packet with a source-ID header byte. The block sits upstream of the TX FIFO that feeds uart_tx; uart_tx drains that FIFO independently. An idle-timeout watchdog frees the FIFO if a granted source stalls mid-packet.

Parameters:
NumRequesters, 4, number of sources (2..8)
DataLength, 8, byte width; must match TX FIFO/uart_tx DataLength
HeaderEnable, 1'b1, 1 = insert header byte before each packet, 0 = no header
HeaderBase, 8'hA0, header byte = HeaderBase | granted index (index in low $clog2(NumRequesters) bits; those bits of HeaderBase must be 0)
IdleTimeout, 64, max consecutive starved cycles in DATA before abort; 0 = watchdog disabled

Ports:
i_clk  in  1  system clock (same domain as TX FIFO write side)
i_rst  in  1  asynchronous, active-high reset
i_req_valid  in  NumRequesters  per-source byte valid
i_req_data  in  NumRequesters*DataLength  source k byte at [k*DataLength +: DataLength]
i_req_last  in  NumRequesters  per-source last-byte-of-packet flag, qualified by valid
o_req_ready  out  NumRequesters  per-source accept; byte transfers when valid & ready
i_tx_fifo_full  in  1  TX FIFO full
o_tx_fifo_write_en  out  1  TX FIFO write strobe
o_tx_fifo_data  out  DataLength  TX FIFO write data
o_grant  out  NumRequesters  registered one-hot grant, all-zero when idle
o_busy  out  1  high in HEADER or DATA
o_abort  out  1  one-cycle pulse when the watchdog aborts a packet

Behaviour:
- Reset (async, i_rst=1): state IDLE; grant=0; rr pointer=0; timeout counter=0; o_abort=0. All outputs are 0 during and after reset until a grant is issued.
- States: IDLE, HEADER, DATA. Grant index g and rr pointer are registered.
- IDLE: sample i_req_valid. Search sources starting at pointer, wrapping modulo NumRequesters, and pick the first valid source. On the next edge: g=winner, o_grant=onehot(g), pointer=(g+1) mod NumRequesters, state=HEADER if HeaderEnable else DATA. If no source is valid, stay in IDLE. Requests are sampled only in IDLE.
- HEADER: o_tx_fifo_data=HeaderBase|g; o_tx_fifo_write_en=!i_tx_fifo_full; all o_req_ready=0. Move to DATA on the edge where the write occurs.
- DATA: o_req_ready[g]=!i_tx_fifo_full; all other o_req_ready=0. o_tx_fifo_write_en=i_req_valid[g]&!i_tx_fifo_full. o_tx_fifo_data=i_req_data[g] (combinational pass-through, zero latency).
- Packet end: a write in DATA with i_req_last[g]=1 moves the FSM to IDLE. o_grant clears on the same edge. There is exactly one arbitration cycle in IDLE between packets.
- Write gating: o_tx_fifo_write_en is never asserted while i_tx_fifo_full=1. A full FIFO stalls HEADER/DATA indefinitely.
- Watchdog (IdleTimeout>0):
  - The counter resets on entry to DATA and on every write.
  - It increments on DATA cycles with i_req_valid[g]=0. Cycles stalled by a full FIFO do not count.
  - When the counter reaches IdleTimeout: o_abort pulses for 1 cycle, the FSM goes to IDLE, and the grant clears. Bytes already written stay in the FIFO; the arbiter inserts no trailer.
- Counter width: $clog2(IdleTimeout+1); it saturates and cannot wrap.
- Non-granted sources holding valid see ready=0; their data is ignored.
- Reset mid-packet clears state immediately. A partial packet may remain in the FIFO; clearing it is the FIFO's responsibility.
- A packet is at least one data byte; a header is never written alone except on abort.
- o_tx_fifo_write_en and o_req_ready are combinational from state/registers and i_tx_fifo_full/i_req_valid. There is no combinational path from i_req_valid to o_grant.

Test Plan:
- Single source: src1 sends 3 bytes 11,22,33 (last on 33), FIFO never full -> FIFO receives A1,11,22,33 on consecutive cycles after 1 IDLE cycle; o_grant=0010 then 0000; o_busy high 4 cycles.
- Round-robin: src0 and src2 both send continuous 2-byte packets -> packet order src0,src2,src0,src2; headers A0,A2,A0,A2; no interleaving of bytes.
- Back-pressure: i_tx_fifo_full=1 for 5 cycles in the middle of the DATA phase -> no writes and o_req_ready[g]=0 during those cycles; no abort; packet completes intact.
- Watchdog: IdleTimeout=4; src3 sends header+1 byte, then drops valid -> o_abort pulses 4 cycles after the last write; grant clears; waiting src0 is granted next.
- HeaderEnable=0 with wrap: pointer=3 and sources 0 and 3 requesting -> src3 wins; src3 bytes are written with no header; src0 is granted next.
- Async reset asserted mid-DATA -> o_grant, o_busy, o_tx_fifo_write_en and o_req_ready drop immediately; after release the first grant goes to the lowest valid index (pointer=0).

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet arbiter sharing one UART TX FIFO write port
module uart_tx_arbiter #(
  parameter int                    NumRequesters = 4,
  parameter int                    DataLength    = 8,
  parameter bit                    HeaderEnable  = 1'b1,
  parameter logic [DataLength-1:0] HeaderBase    = 8'hA0,
  parameter int                    IdleTimeout   = 64
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  input  logic [NumRequesters-1:0]           i_req_valid,
  input  logic [NumRequesters*DataLength-1:0] i_req_data,
  input  logic [NumRequesters-1:0]           i_req_last,
  output logic [NumRequesters-1:0]           o_req_ready,
  input  logic                               i_tx_fifo_full,
  output logic                               o_tx_fifo_write_en,
  output logic [DataLength-1:0]              o_tx_fifo_data,
  output logic [NumRequesters-1:0]           o_grant,
  output logic                               o_busy,
  output logic                               o_abort
);

  localparam int IW = $clog2(NumRequesters);
  // Watchdog counter only needs to reach IdleTimeout; keep one bit when disabled.
  localparam int CW = (IdleTimeout > 0) ? $clog2(IdleTimeout + 1) : 1;
  localparam logic [IW:0]   NR       = (IW + 1)'(NumRequesters);
  localparam logic [IW-1:0] LAST_IDX = IW'(NumRequesters - 1);
  localparam logic [CW-1:0] TMO      = CW'(IdleTimeout);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t                    state, state_nx;
  logic [IW-1:0]             g, g_nx;
  logic [IW-1:0]             ptr, ptr_nx;
  logic [NumRequesters-1:0]  grant, grant_nx;
  logic [CW-1:0]             cnt, cnt_nx;
  logic                      abort, abort_nx;

  logic                      found;
  logic [IW-1:0]             winner;
  logic [IW:0]               idx_w;

  logic                      sel_valid;
  logic                      sel_last;
  logic [DataLength-1:0]     sel_data;
  logic                      hdr_wr;
  logic                      dat_wr;
  logic                      starve;

  // Granted source's stream, selected by the registered grant index.
  assign sel_valid = i_req_valid[g];
  assign sel_last  = i_req_last[g];
  assign sel_data  = i_req_data[g*DataLength +: DataLength];

  // A full FIFO freezes both the write and the watchdog.
  assign hdr_wr = (state == HEADER) && !i_tx_fifo_full;
  assign dat_wr = (state == DATA) && sel_valid && !i_tx_fifo_full;
  assign starve = (state == DATA) && !sel_valid && !i_tx_fifo_full;

  assign o_grant = grant;
  assign o_busy  = (state != IDLE);
  assign o_abort = abort;

  // State and arbitration registers; reset returns to an idle, ungranted arbiter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
      g     <= '0;
      ptr   <= '0;
      grant <= '0;
      cnt   <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_nx;
      g     <= g_nx;
      ptr   <= ptr_nx;
      grant <= grant_nx;
      cnt   <= cnt_nx;
      abort <= abort_nx;
    end
  end

  // Next state: round-robin pick in IDLE, packet tracking and watchdog in HEADER/DATA.
  always_comb begin
    state_nx = state;
    g_nx     = g;
    ptr_nx   = ptr;
    grant_nx = grant;
    cnt_nx   = cnt;
    abort_nx = 1'b0;
    found    = 1'b0;
    winner   = '0;
    idx_w    = '0;

    for (int i = 0; i < NumRequesters; i++) begin
      idx_w = {1'b0, ptr} + (IW + 1)'(i);
      if (idx_w >= NR) begin
        idx_w = idx_w - NR;
      end
      if (!found && i_req_valid[idx_w[IW-1:0]]) begin
        found  = 1'b1;
        winner = idx_w[IW-1:0];
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          g_nx     = winner;
          grant_nx = NumRequesters'(1) << winner;
          ptr_nx   = (winner == LAST_IDX) ? '0 : winner + 1'b1;
          cnt_nx   = '0;
          state_nx = HeaderEnable ? HEADER : DATA;
        end
      end
      HEADER: begin
        if (hdr_wr) begin
          cnt_nx   = '0;
          state_nx = DATA;
        end
      end
      DATA: begin
        if (dat_wr) begin
          cnt_nx = '0;
          if (sel_last) begin
            state_nx = IDLE;
            grant_nx = '0;
          end
        end else if ((IdleTimeout > 0) && starve) begin
          if (cnt != TMO) begin
            cnt_nx = cnt + CW'(1);
          end
          if (cnt_nx == TMO) begin
            abort_nx = 1'b1;
            state_nx = IDLE;
            grant_nx = '0;
          end
        end
      end
      default: begin
        state_nx = IDLE;
        grant_nx = '0;
      end
    endcase
  end

  // Outputs: header byte in HEADER, zero-latency pass-through of the granted source in DATA.
  always_comb begin
    o_req_ready        = '0;
    o_tx_fifo_write_en = 1'b0;
    o_tx_fifo_data     = '0;
    case (state)
      HEADER: begin
        o_tx_fifo_write_en = !i_tx_fifo_full;
        o_tx_fifo_data     = HeaderBase | DataLength'(g);
      end
      DATA: begin
        o_req_ready[g]     = !i_tx_fifo_full;
        o_tx_fifo_write_en = sel_valid && !i_tx_fifo_full;
        o_tx_fifo_data     = sel_data;
      end
      default: begin
        o_req_ready        = '0;
      end
    endcase
  end

endmodule
